// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int WSTRB_W = 4;

endpackage

// File: rtl/arb2_rr.sv
// rtl/arb2_rr.sv - 2-way fixed-priority / round-robin arbiter, one-hot grant
module arb2_rr #(
  parameter int PRIO = 1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Bit 1 is the priority requester; on a round-robin tie the port other than last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (PRIO != 0) begin
        gnt = 2'b10;
      end else begin
        gnt = last ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port SRAM between fetch (I) and load/store (D)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ready,
  output logic               i_rvalid,
  output logic [DATA_W-1:0]  i_rdata,
  input  logic               i_rready,
  input  logic               d_req,
  input  logic               d_wr,
  input  logic [WSTRB_W-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_ready,
  output logic               d_rvalid,
  output logic [DATA_W-1:0]  d_rdata,
  input  logic               d_rready,
  output logic               sram_en,
  output logic [WSTRB_W-1:0] sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata
);

  state_t            state;
  logic              owner;
  logic              owner_wr;
  logic              last_grant;
  logic [DATA_W-1:0] rsp_buf;

  logic              busy;
  logic              rsp_take;
  logic              can_issue;
  logic [1:0]        gnt;
  logic              gnt_i;
  logic              gnt_d;
  logic [DATA_W-1:0] rsp_data;

  assign busy      = (state == ST_WAIT) || (state == ST_HOLD);
  assign rsp_take  = busy && ((owner == OWN_D) ? d_rready : i_rready);
  assign can_issue = (state == ST_IDLE) || rsp_take;

  arb2_rr #(
    .PRIO (DATA_PRIO)
  ) u_arb (
    .req  ({d_req & can_issue, i_req & can_issue}),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign gnt_d = gnt[1];
  assign gnt_i = gnt[0];

  assign i_ready    = gnt_i;
  assign d_ready    = gnt_d;
  assign sram_en    = gnt_i | gnt_d;
  assign sram_addr  = gnt_d ? d_addr : (gnt_i ? i_addr : '0);
  assign sram_we    = (gnt_d && d_wr) ? d_wstrb : '0;
  assign sram_wdata = gnt_d ? d_wdata : '0;

  // Writes return a zero ack word so both ports see identical response timing.
  always_comb begin
    rsp_data = '0;
    if (state == ST_WAIT) begin
      rsp_data = owner_wr ? '0 : sram_rdata;
    end else if (state == ST_HOLD) begin
      rsp_data = rsp_buf;
    end
  end

  assign i_rvalid = busy && (owner == OWN_I);
  assign d_rvalid = busy && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? rsp_data : '0;
  assign d_rdata  = d_rvalid ? rsp_data : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      owner_wr   <= 1'b0;
      last_grant <= OWN_D;
      rsp_buf    <= '0;
    end else begin
      if (sram_en) begin
        state      <= ST_WAIT;
        owner      <= gnt_d ? OWN_D : OWN_I;
        owner_wr   <= gnt_d & d_wr;
        last_grant <= gnt_d ? OWN_D : OWN_I;
      end else if (rsp_take) begin
        state <= ST_IDLE;
      end else if (state == ST_WAIT) begin
        // SRAM data is only valid for one cycle, so park it until the owner drains it.
        state   <= ST_HOLD;
        rsp_buf <= owner_wr ? '0 : sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter, fixed-priority and round-robin
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_rready, d_req, d_wr, d_rready;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  logic        i_ready_p, i_rvalid_p, d_ready_p, d_rvalid_p, sram_en_p;
  logic [31:0] i_rdata_p, d_rdata_p, sram_addr_p, sram_wdata_p, sram_rdata_p;
  logic [3:0]  sram_we_p;
  logic        i_ready_r, i_rvalid_r, d_ready_r, d_rvalid_r, sram_en_r;
  logic [31:0] i_rdata_r, d_rdata_r, sram_addr_r, sram_wdata_r, sram_rdata_r;
  logic [3:0]  sram_we_r;

  logic [31:0] mem [0:1023];
  logic [31:0] qi[$], qd[$], qri[$], qrd[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mode;

  localparam logic [31:0] RR_KEY = 32'h5A5A5A5A;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1)) dut_p (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_p), .i_rvalid(i_rvalid_p),
    .i_rdata(i_rdata_p), .i_rready(i_rready),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready_p), .d_rvalid(d_rvalid_p), .d_rdata(d_rdata_p), .d_rready(d_rready),
    .sram_en(sram_en_p), .sram_we(sram_we_p), .sram_addr(sram_addr_p),
    .sram_wdata(sram_wdata_p), .sram_rdata(sram_rdata_p)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0)) dut_r (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_r), .i_rvalid(i_rvalid_r),
    .i_rdata(i_rdata_r), .i_rready(i_rready),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready_r), .d_rvalid(d_rvalid_r), .d_rdata(d_rdata_r), .d_rready(d_rready),
    .sram_en(sram_en_r), .sram_we(sram_we_r), .sram_addr(sram_addr_r),
    .sram_wdata(sram_wdata_r), .sram_rdata(sram_rdata_r)
  );

  // Idle cycles return garbage so a missing response buffer cannot hide.
  always @(posedge clk) begin
    if (sram_en_p) begin
      sram_rdata_p <= mem[sram_addr_p[11:2]];
      for (int b = 0; b < 4; b++)
        if (sram_we_p[b]) mem[sram_addr_p[11:2]][8*b +: 8] <= sram_wdata_p[8*b +: 8];
    end else begin
      sram_rdata_p <= $urandom();
    end
    sram_rdata_r <= sram_en_r ? (sram_addr_r ^ RR_KEY) : $urandom();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mode == 1'b0) begin
      if (i_rvalid_p && i_rready) begin
        if (qi.size() == 0) chk("i_rsp_unexpected", {31'b0, i_rvalid_p}, 32'd0);
        else chk("i_rsp", i_rdata_p, qi.pop_front());
      end
      if (d_rvalid_p && d_rready) begin
        if (qd.size() == 0) chk("d_rsp_unexpected", {31'b0, d_rvalid_p}, 32'd0);
        else chk("d_rsp", d_rdata_p, qd.pop_front());
      end
    end else begin
      if (i_rvalid_r && i_rready) begin
        if (qri.size() == 0) chk("rr_i_rsp_unexpected", {31'b0, i_rvalid_r}, 32'd0);
        else chk("rr_i_rsp", i_rdata_r, qri.pop_front());
      end
      if (d_rvalid_r && d_rready) begin
        if (qrd.size() == 0) chk("rr_d_rsp_unexpected", {31'b0, d_rvalid_r}, 32'd0);
        else chk("rr_d_rsp", d_rdata_r, qrd.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    mode = 1'b0;
    resetn = 1'b0;
    i_req = 0; i_rready = 0; d_req = 0; d_wr = 0; d_rready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    for (int k = 0; k < 4; k++) mem[k] = 32'hF00D_0000 + k;
    mem[64]  = 32'hDEADBEEF;
    mem[128] = 32'hAAAAAAAA;
    mem[129] = 32'h55555555;

    // Reset state
    repeat (2) @(posedge clk);
    cyc();
    chk("rst_i_ready", {31'b0, i_ready_p}, 0);
    chk("rst_d_ready", {31'b0, d_ready_p}, 0);
    chk("rst_i_rvalid", {31'b0, i_rvalid_p}, 0);
    chk("rst_d_rvalid", {31'b0, d_rvalid_p}, 0);
    chk("rst_sram_en", {31'b0, sram_en_p}, 0);
    chk("rst_d_rdata", d_rdata_p, 0);
    nxt(); resetn = 1'b1;

    // Reset during WAIT discards the in-flight fetch
    nxt(); i_req = 1; i_addr = 32'h1c000000; i_rready = 1;
    cyc();
    chk("mw_grant", {31'b0, i_ready_p}, 1);
    chk("mw_sram_addr", sram_addr_p, 32'h1c000000);
    nxt(); i_req = 0; resetn = 1'b0;
    cyc();
    chk("mw_rvalid", {31'b0, i_rvalid_p}, 0);
    chk("mw_sram_en", {31'b0, sram_en_p}, 0);
    nxt(); resetn = 1'b1; i_req = 1;
    cyc();
    chk("mw_regrant", {31'b0, i_ready_p}, 1);
    qi.push_back(32'hF00D_0000);
    nxt(); i_req = 0;
    cyc();

    // Simultaneous requests, D has priority
    nxt(); d_req = 1; d_wr = 0; d_addr = 32'h100; d_rready = 1; i_req = 1; i_addr = 32'h1c000004;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("prio_d_ready", {31'b0, d_ready_p}, 1);
      chk("prio_i_ready", {31'b0, i_ready_p}, 0);
      qd.push_back(32'hDEADBEEF);
      nxt();
    end
    d_req = 0;
    cyc();
    chk("prio_i_after", {31'b0, i_ready_p}, 1);
    qi.push_back(32'hF00D_0001);
    nxt(); i_req = 0;
    cyc();

    // Response stall into HOLD, release grants pending fetch
    nxt(); d_req = 1; d_addr = 32'h100; d_rready = 0;
    cyc();
    chk("stall_d_ready", {31'b0, d_ready_p}, 1);
    qd.push_back(32'hDEADBEEF);
    nxt(); d_req = 0; i_req = 1; i_addr = 32'h1c000008;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_d_rvalid", {31'b0, d_rvalid_p}, 1);
      chk("stall_d_rdata", d_rdata_p, 32'hDEADBEEF);
      chk("stall_sram_en", {31'b0, sram_en_p}, 0);
      chk("stall_i_ready", {31'b0, i_ready_p}, 0);
      nxt();
    end
    d_rready = 1;
    cyc();
    chk("stall_release_grant", {31'b0, i_ready_p}, 1);
    qi.push_back(32'hF00D_0002);
    nxt(); i_req = 0;
    cyc();

    // Byte write, readback, and a zero-strobe write
    nxt(); d_req = 1; d_wr = 1; d_addr = 32'h200; d_wstrb = 4'b0110; d_wdata = 32'h11223344;
    cyc();
    chk("bw_d_ready", {31'b0, d_ready_p}, 1);
    chk("bw_sram_we", {28'b0, sram_we_p}, 32'h6);
    chk("bw_sram_wdata", sram_wdata_p, 32'h11223344);
    qd.push_back(32'h0);
    nxt(); d_wr = 0;
    cyc();
    chk("bw_ack_rvalid", {31'b0, d_rvalid_p}, 1);
    chk("bw_rd_we", {28'b0, sram_we_p}, 0);
    qd.push_back(32'hAA2233AA);
    nxt(); d_wr = 1; d_addr = 32'h204; d_wstrb = 4'b0000; d_wdata = 32'hFFFFFFFF;
    cyc();
    chk("zw_sram_en", {31'b0, sram_en_p}, 1);
    chk("zw_sram_we", {28'b0, sram_we_p}, 0);
    qd.push_back(32'h0);
    nxt(); d_wr = 0;
    cyc();
    qd.push_back(32'h55555555);
    nxt(); d_req = 0;
    cyc();

    // Back-to-back fetch stream
    nxt(); i_req = 1;
    for (int k = 0; k < 4; k++) begin
      i_addr = 32'h1c000000 + 32'(4 * k);
      cyc();
      chk("b2b_i_ready", {31'b0, i_ready_p}, 1);
      chk("b2b_sram_addr", sram_addr_p, 32'h1c000000 + 32'(4 * k));
      if (k > 0) chk("b2b_rvalid", {31'b0, i_rvalid_p}, 1);
      qi.push_back(32'hF00D_0000 + 32'(k));
      nxt();
    end
    i_req = 0;
    cyc();
    chk("b2b_last_rvalid", {31'b0, i_rvalid_p}, 1);

    // Round-robin from reset: I,D,I,D
    nxt(); resetn = 1'b0; mode = 1'b1;
    nxt(); resetn = 1'b1;
    i_req = 1; d_req = 1; d_wr = 0; i_addr = 32'h1c000010; d_addr = 32'h300;
    i_rready = 1; d_rready = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_i_ready", {31'b0, i_ready_r}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_d_ready", {31'b0, d_ready_r}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_sram_en", {31'b0, sram_en_r}, 1);
      if (k > 0) begin
        chk("rr_i_rvalid", {31'b0, i_rvalid_r}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_d_rvalid", {31'b0, d_rvalid_r}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      if (k % 2 == 0) qri.push_back(32'h1c000010 ^ RR_KEY);
      else qrd.push_back(32'h300 ^ RR_KEY);
      nxt();
    end
    i_req = 0; d_req = 0;
    cyc();
    chk("rr_last_d_rvalid", {31'b0, d_rvalid_r}, 1);
    nxt();
    cyc();

    chk("qi_empty", 32'(qi.size()), 0);
    chk("qd_empty", 32'(qd.size()), 0);
    chk("qri_empty", 32'(qri.size()), 0);
    chk("qrd_empty", 32'(qrd.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares one single-port synchronous SRAM between the instruction-fetch requester (port I, read-only) and the load/store requester (port D, read/write). It arbitrates requests, drives the SRAM port, and routes each 1-cycle-latency response back to its owner. It buffers that response when the owner stalls. It sits between the fetch/memory stages and the unified SRAM; at most one access is outstanding at any time.

Parameters:
ADDR_W, 32, address width for both requesters and the SRAM.
DATA_W, 32, data width; must be 32 (byte strobe is 4 bits).
DATA_PRIO, 1, 1 = port D has fixed priority over port I; 0 = round-robin.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
i_req  in  1  fetch request valid; held with i_addr stable until i_ready
i_addr  in  ADDR_W  fetch address
i_ready  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch response valid
i_rdata  out  DATA_W  fetch read data
i_rready  in  1  fetch stage accepts response
d_req  in  1  data request valid; held stable until d_ready
d_wr  in  1  1 = write, 0 = read
d_wstrb  in  4  byte write enables (ignored on read)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ready  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid (read data, or write ack)
d_rdata  out  DATA_W  read data; 0 for write ack
d_rready  in  1  memory stage accepts response
sram_en  out  1  SRAM access enable
sram_we  out  4  SRAM byte write enable
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en

Behaviour:
- States: IDLE (nothing outstanding), WAIT (SRAM access issued last cycle; response is sram_rdata this cycle), HOLD (response captured in buffer; owner not yet ready).
- Registers: state, owner (I/D), owner_wr, rsp_buf[DATA_W], last_grant (RR pointer).
- Response consumed (rsp_take) = state in {WAIT, HOLD} and owner's rready = 1.
- Accept window (can_issue) = state==IDLE, or rsp_take.
- Grant, computed combinationally in the can_issue cycle:
  - DATA_PRIO=1: D wins if d_req, else I.
  - DATA_PRIO=0: with both requesting, the port not equal to last_grant wins; a single requester always wins.
- Granted port: its ready=1, sram_en=1, and sram_addr/we/wdata driven from it. sram_we = d_wstrb if d_wr, else 0. I is always a read.
- Ungranted port: ready=0. sram_en=0 when no grant.
- Next state:
  - Grant → WAIT, and owner/owner_wr/last_grant are updated.
  - WAIT with rsp_take and no new grant → IDLE.
  - WAIT without rsp_take → HOLD, with rsp_buf <= (owner_wr ? 0 : sram_rdata).
  - HOLD with rsp_take and no grant → IDLE.
- Response outputs:
  - Owner's rvalid = state in {WAIT, HOLD}; the other port's rvalid = 0.
  - rdata: in WAIT, owner_wr ? 0 : sram_rdata; in HOLD, rsp_buf.
  - Non-owner rdata = 0.
- Back-to-back: a response accepted and a new request granted in the same cycle gives one access per cycle, full throughput.
- Write ack follows the read timing: d_rvalid the cycle after d_ready, with d_rdata=0. A write with wstrb=0 is still issued and acked.
- Owner is not required to request again; sram_en stays 0 in WAIT/HOLD unless rsp_take.
- Reset (async, any time): state=IDLE, owner=I, owner_wr=0, rsp_buf=0, last_grant=D (so I wins the first RR tie).
  - All outputs are 0 during and after reset until a request arrives.
  - Any in-flight response is discarded.
- No combinational path from sram_rdata to any ready; ready depends on req, rready and state only.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state enum ST_IDLE/ST_WAIT/ST_HOLD;
  - owner constants OWN_I=0, OWN_D=1;
  - WSTRB_W=4.
- One sub-module: arb2_rr, a 2-way fixed/round-robin arbiter with a PRIO parameter that outputs a one-hot grant. Pointer update stays in the parent.

Test Plan:
- Reset mid-WAIT: issue I read at 0x1c000000, drop resetn the next cycle → i_rvalid=0, sram_en=0, state IDLE. After release, a single i_req is granted immediately.
- Simultaneous requests, DATA_PRIO=1: i_req=d_req=1 for 4 cycles → d_ready asserted every issue slot, i_ready=0 until d_req drops.
- Round-robin, DATA_PRIO=0, both requesters continuously, rready=1 → grants alternate I,D,I,D from reset, one sram_en per cycle, each rvalid one cycle after its ready.
- Response stall: preload mem[0x100]=0xDEADBEEF; D read 0x100 with d_rready=0 for 3 cycles →
  - state goes to HOLD with d_rdata=0xDEADBEEF held;
  - no further sram_en while HOLD;
  - the same cycle d_rready=1, a pending i_req is granted.
- Byte write: D write 0x200, wstrb=4'b0110, wdata=0x11223344 over 0xAAAAAAAA →
  - sram_we=0110;
  - d_rvalid next cycle with d_rdata=0;
  - a subsequent read returns 0xAA2233AA.
- Back-to-back fetch, I streaming 0x1c000000..0x1c00000c with i_rready=1 → four accesses in four consecutive cycles, responses in order, no bubbles.
